// File: rtl/seq_cmp.sv
// seq_cmp -- sequential magnitude comparator.
//
// Compares two WIDTH-bit operands one SLICE-bit slice per clock, starting
// with the most significant slice. It stops at the first slice that
// differs, so the latency depends on the data.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   flush      synchronous abort back to IDLE; overrides every other event
//   in_valid   request strobe (a, b, is_signed, zero_mode are valid)
//   in_ready   high only in IDLE, when a request can be accepted
//   a, b       operands (b is replaced by 0 when zero_mode=1)
//   is_signed  1 = two's-complement compare, 0 = unsigned compare
//   zero_mode  1 = compare a against zero
//   out_valid  cmp_res holds a result; held until out_ready
//   out_ready  consumer accepts the result
//   cmp_res    00 equal, 01 a greater, 10 a less
//   busy       high while an operation is in RUN or DONE
module seq_cmp #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  input  logic             zero_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       cmp_res,
  output logic             busy
);

  localparam int NSL = WIDTH / SLICE;
  localparam int IW  = (NSL > 1) ? $clog2(NSL) : 1;
  localparam logic [IW-1:0] LAST = IW'(NSL - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [1:0] RES_EQ = 2'b00;
  localparam logic [1:0] RES_GT = 2'b01;
  localparam logic [1:0] RES_LT = 2'b10;

  logic [1:0]       state;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             sgn_q;
  logic [SLICE-1:0] sa;
  logic [SLICE-1:0] sb;

  // Unsigned compare of two slices into the result encoding.
  function automatic logic [1:0] slice_cmp(input logic [SLICE-1:0] x,
                                           input logic [SLICE-1:0] y);
    if (x > y)      return RES_GT;
    else if (x < y) return RES_LT;
    else            return RES_EQ;
  endfunction

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // Select the active slice. Flipping the sign bit of both operands in the
  // top slice maps two's-complement ordering onto unsigned ordering; lower
  // slices are already plain magnitude bits.
  always_comb begin
    sa = '0;
    sb = '0;
    for (int i = 0; i < NSL; i++) begin
      if (idx == IW'(i)) begin
        sa = a_q[i*SLICE +: SLICE];
        sb = b_q[i*SLICE +: SLICE];
      end
    end
    if (sgn_q && (idx == LAST)) begin
      sa[SLICE-1] = ~sa[SLICE-1];
      sb[SLICE-1] = ~sb[SLICE-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sgn_q     <= 1'b0;
      out_valid <= 1'b0;
      cmp_res   <= RES_EQ;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      cmp_res   <= RES_EQ;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= zero_mode ? '0 : b;
            sgn_q <= is_signed;
            idx   <= LAST;
            state <= RUN;
          end
        end
        RUN: begin
          if (sa != sb) begin
            // First differing slice decides; no need to look further.
            cmp_res   <= slice_cmp(sa, sb);
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (idx == '0) begin
            cmp_res   <= RES_EQ;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_cmp.sv
// Self-checking bench for seq_cmp (WIDTH=32, SLICE=8): directed cases for
// the documented corner behaviour plus randomized operations checked
// against an arithmetic reference model.
module tb_seq_cmp;

  localparam int WIDTH = 32;
  localparam int SLICE = 8;
  localparam int NSL   = WIDTH / SLICE;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             is_signed;
  logic             zero_mode;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       cmp_res;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;

  seq_cmp #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .is_signed (is_signed),
    .zero_mode (zero_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cmp_res   (cmp_res),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: result from plain integer ordering; latency is the number of
  // slices from the top down to and including the first differing one.
  task automatic model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                       input bit s, input bit zm,
                       output logic [1:0] r, output int k);
    longint va, vb;
    logic [WIDTH-1:0] bb, d;
    bb = zm ? '0 : mb;
    if (s) begin
      va = longint'($signed(ma));
      vb = longint'($signed(bb));
    end else begin
      va = longint'({32'd0, ma});
      vb = longint'({32'd0, bb});
    end
    r = (va > vb) ? 2'b01 : (va < vb) ? 2'b10 : 2'b00;
    d = ma ^ bb;
    k = NSL;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (d[i]) begin
        k = NSL - (i / SLICE);
        break;
      end
    end
  endtask

  // One full transaction. Inputs are driven 1 time unit after a rising edge
  // and outputs sampled at the same offset. hold = cycles out_ready stays
  // low once the result is up; junk = present a competing request meanwhile.
  task automatic run_op(input string tag, input logic [WIDTH-1:0] ta,
                        input logic [WIDTH-1:0] tb, input bit s, input bit zm,
                        input int hold, input bit junk);
    logic [1:0] er;
    int ek, lat;
    model(ta, tb, s, zm, er, ek);
    chk({tag, ".in_ready_idle"}, in_ready, 1);
    a = ta; b = tb; is_signed = s; zero_mode = zm; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = junk;
    if (junk) begin a = ~ta; b = ta; is_signed = ~s; zero_mode = 1'b0; end
    chk({tag, ".busy_run"}, {busy, in_ready}, 2'b10);
    lat = 0;
    for (int i = 1; i <= 3 * NSL; i++) begin
      if (out_valid) begin lat = i - 1; break; end
      @(posedge clk); #1;
      if (out_valid) begin lat = i; break; end
    end
    chk({tag, ".latency"}, lat, ek);
    chk({tag, ".cmp_res"}, cmp_res, er);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, ".hold"}, {out_valid, in_ready, busy, cmp_res}, {3'b101, er});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    // A request present on the consume edge must not have been taken.
    chk({tag, ".consumed"}, {out_valid, in_ready, busy}, 3'b010);
    in_valid = 1'b0;
  endtask

  logic [1:0] r_unused;
  int k_unused;
  bit seen;

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; is_signed = 1'b0; zero_mode = 1'b0;
    #1;
    chk("reset_state", {out_valid, cmp_res, busy, in_ready}, 5'b00001);
    #12 rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("eq5",       32'd5,        32'd5, 1'b1, 1'b0, 0, 1'b0);
    run_op("neg1_s",    32'hFFFFFFFF, 32'd1, 1'b1, 1'b0, 0, 1'b0);
    run_op("neg1_u",    32'hFFFFFFFF, 32'd1, 1'b0, 1'b0, 0, 1'b0);
    run_op("zm_min",    32'h80000000, 32'h7, 1'b1, 1'b1, 0, 1'b0);
    run_op("zm_zero",   32'h0,        32'h7, 1'b1, 1'b1, 0, 1'b0);
    run_op("zm_100",    32'h00000100, 32'h7, 1'b1, 1'b1, 0, 1'b0);
    run_op("hold3",     32'h12345678, 32'h12345679, 1'b0, 1'b0, 3, 1'b1);
    run_op("after_hold", 32'h00000010, 32'h00000020, 1'b0, 1'b0, 0, 1'b0);

    // Asynchronous reset in the middle of RUN; no result may follow.
    a = 32'd9; b = 32'd9; is_signed = 1'b0; zero_mode = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("rst_async", {out_valid, cmp_res, busy, in_ready}, 5'b00001);
    #3 rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 2 * NSL; i++) begin
      @(posedge clk); #1;
      if (out_valid || busy) seen = 1'b1;
    end
    chk("rst_no_result", seen, 0);
    run_op("post_rst",  32'h00AB0000, 32'h00AC0000, 1'b1, 1'b0, 0, 1'b0);

    // Flush in DONE together with out_ready and a new request.
    a = 32'hFFFFFFFF; b = 32'd1; is_signed = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("flush_pre_done", {out_valid, cmp_res}, 3'b101);
    flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    chk("flush_done", {out_valid, cmp_res, busy, in_ready}, 5'b00001);

    // Flush during RUN abandons the operation.
    a = 32'd3; b = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 2 * NSL; i++) begin
      @(posedge clk); #1;
      if (out_valid || busy) seen = 1'b1;
    end
    chk("flush_run", seen, 0);

    // Randomized operations; b often shares upper slices with a so that
    // every latency shows up.
    for (int n = 0; n < 60; n++) begin
      logic [WIDTH-1:0] ra, rb;
      int cut;
      ra = $urandom;
      rb = $urandom;
      cut = $urandom_range(0, NSL);
      if (cut > 0 && $urandom_range(0, 3) != 0) begin
        for (int i = WIDTH - 1; i >= WIDTH - cut * SLICE; i--) rb[i] = ra[i];
      end
      model(ra, rb, 1'b0, 1'b0, r_unused, k_unused);
      run_op($sformatf("rnd%0d", n), ra, rb, $urandom_range(0, 1) == 1,
             $urandom_range(0, 5) == 0, $urandom_range(0, 3),
             $urandom_range(0, 1) == 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_cmp.md
SEQ_CMP -- requirements
Module: seq_cmp

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits.
REQ-002 SHALL have parameter SLICE, default 8, bits compared per cycle; WIDTH SHALL be an integer multiple of SLICE; NSL = WIDTH/SLICE.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port flush  input  1  synchronous abort; returns the block to IDLE.
REQ-006 SHALL have port in_valid  input  1  request presents a, b, is_signed and zero_mode.
REQ-007 SHALL have port in_ready  output  1  block accepts a request this cycle.
REQ-008 SHALL have port a  input  WIDTH  first operand.
REQ-009 SHALL have port b  input  WIDTH  second operand; ignored when zero_mode=1.
REQ-010 SHALL have port is_signed  input  1  1 = two's-complement compare, 0 = unsigned compare.
REQ-011 SHALL have port zero_mode  input  1  1 = compare a against 0 instead of b.
REQ-012 SHALL have port out_valid  output  1  cmp_res holds a valid result.
REQ-013 SHALL have port out_ready  input  1  consumer takes the result.
REQ-014 SHALL have port cmp_res  output  2  result code: 00 equal, 01 a greater, 10 a less; 11 never driven.
REQ-015 SHALL have port busy  output  1  high in RUN and DONE.

Function
REQ-016 SHALL implement the FSM states IDLE, RUN and DONE; in_ready SHALL be 1 only in IDLE.
REQ-017 In IDLE, when in_valid=1, the block SHALL capture a, b (or 0 if zero_mode=1) and is_signed, load slice index NSL-1, and enter RUN.
REQ-018 Each RUN cycle SHALL compare one SLICE-bit slice, MSB slice first, index decrementing by 1.
REQ-019 For the signed compare, the block SHALL invert the operand MSB of both operands in the top slice only, then compare unsigned.
REQ-020 If the current slices differ, the block SHALL register 01 or 10 into cmp_res, set out_valid=1 and enter DONE at that edge (early termination).
REQ-021 If slice index 0 compares equal, the block SHALL register 00 into cmp_res, set out_valid=1 and enter DONE.
REQ-022 Latency from the acceptance edge to out_valid=1 SHALL be k edges, where k is the number of slices examined, 1 <= k <= NSL.
REQ-023 In DONE, cmp_res and out_valid SHALL hold stable until out_ready=1; on that edge the block SHALL clear out_valid and enter IDLE.
REQ-024 The block SHALL NOT accept a request in the cycle a result is consumed; in_ready SHALL rise on the following cycle.
REQ-025 While busy, the block SHALL ignore in_valid, a and b; captured operands SHALL NOT change.
REQ-026 flush=1 SHALL force IDLE, out_valid=0 and cmp_res=00 at the next edge, overriding every other event, including a same-cycle in_valid or out_ready.
REQ-027 With NSL=1, every result SHALL appear 1 edge after acceptance.

Reset
REQ-028 rst_n=0 SHALL immediately (without a clock edge) force state IDLE, out_valid=0, cmp_res=00, busy=0, in_ready=1, and clear the slice index and operand registers.
REQ-029 Reset asserted during RUN or DONE SHALL discard the operation, and no result SHALL appear after release.
REQ-030 After rst_n rises, the block SHALL accept a request at the first rising edge with in_valid=1.

Verification (WIDTH=32, SLICE=8)
REQ-031 The bench SHALL check: a=5, b=5, is_signed=1 -> cmp_res=00, out_valid 4 edges after acceptance.
REQ-032 The bench SHALL check: a=0xFFFFFFFF, b=1 -> is_signed=1 gives 10, is_signed=0 gives 01, each 1 edge after acceptance.
REQ-033 The bench SHALL check: zero_mode=1, is_signed=1, b=0x7 -> a=0x80000000 gives 10 after 1 edge; a=0 gives 00 after 4 edges; a=0x00000100 gives 01 after 3 edges.
REQ-034 The bench SHALL check: a=0x12345678, b=0x12345679, unsigned, out_ready held low 3 cycles -> cmp_res=10 after 4 edges; cmp_res and out_valid held; in_ready=0 and new in_valid ignored until the handshake; in_ready=1 one cycle later.
REQ-035 The bench SHALL check: rst_n pulsed low mid-RUN -> all outputs reset asynchronously, and no out_valid after release.
REQ-036 The bench SHALL check: flush=1 in DONE together with out_ready=1 -> IDLE with out_valid=0 next edge.
